cpu_fetch: RTL and testbench
============================

// Module: cpu_fetch
// PURPOSE
//  Instruction fetch stage. Owns the fetch PC and issues 32-bit word reads to instruction memory.
//  Each returned word is pushed into the instruction FIFO (cpu_ififo) as one 32-bit write.
//  Redirects (branch/jump/exception) flush the FIFO, discard in-flight data and restart at the target.
// PARAMETERS
//  RESET_VECTOR  32'h00001000  first fetch address after reset; bits [1:0] must be 0
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   synchronous active-high reset
//  branch_flag_i      in   1   one-cycle redirect request
//  branch_target_i    in   32  redirect address, halfword aligned ([0]=0)
//  imem_stb_o         out  1   memory request strobe, held until ack
//  imem_adr_o         out  32  word address ([1:0]=0), stable while stb high
//  imem_ack_i         in   1   memory response valid; at most one per request
//  imem_dat_i         in   32  read data, big-endian halfword order ([31:16] first)
//  ififo_full_i       in   1   FIFO cannot accept a 32-bit write
//  ififo_write_en_o   out  1   push ififo_data_o into FIFO this cycle
//  ififo_data_o       out  32  word pushed
//  ififo_flush_o      out  1   one-cycle pulse: FIFO empties, pointers to 0
//  ififo_skip_o       out  1   with write_en: discard [31:16] of this word (misaligned target)
//  fetch_pc_o         out  32  address of next word to request
// BEHAVIOUR
//  Reset: stb=0, write_en=0, flush=0, skip=0, ififo_data_o=0, imem_adr_o=0,
//   fetch_pc_o=RESET_VECTOR, state=IDLE, skip-pending=0; in-flight ack after reset is ignored.
//  States: IDLE, REQ, DRAIN.
//  IDLE: if !ififo_full_i -> drive stb=1, adr=fetch_pc_o, go REQ (request visible next cycle).
//  REQ:  on ack and no redirect -> write_en=1, data=imem_dat_i (same cycle, 0 latency),
//   skip=skip-pending then clear it; fetch_pc_o+=4 (wraps mod 2^32); stb drops; go IDLE.
//   Without ack: hold stb/adr unchanged.
//  Space rule: request only when !ififo_full_i; fetch is sole FIFO writer, so space at issue
//   guarantees space at ack. write_en never asserted while ififo_full_i=1.
//  Redirect (branch_flag_i=1), any state: flush=1 next cycle; fetch_pc_o=target&~3;
//   skip-pending=target[1]. If a request is outstanding (REQ, no ack same cycle) go DRAIN;
//   else go IDLE. Ack coincident with redirect: data discarded, no write, go IDLE.
//  DRAIN: stb held until ack; response discarded (no write); go IDLE.
//   Redirect in DRAIN: update target, stay DRAIN.
//  Redirect has priority over every other event; flush and write_en never high together.
//  Throughput (baseline): max one word per 2 cycles (ack cycle, then new stb).
// CONFIGURATION
//  CPU_FETCH_SKID_EN defined: one-entry 32-bit skid register plus valid bit.
//   On ack in REQ, stb stays high with adr=fetch_pc_o+4 (back-to-back), if !ififo_full_i and skid empty.
//   Acked word goes to FIFO if !ififo_full_i, else into skid; skid drains first when space appears.
//   New request blocked while skid valid. Redirect clears skid and skid-valid.
//   Peak throughput: one word per cycle.
//  CPU_FETCH_SKID_EN undefined: no skid logic; baseline 2-cycle behaviour above.
// TESTING
//  Reset, 1-cycle-ack memory, FIFO never full -> first adr=0x1000, writes 0x1000,0x1004,... every 2 cycles.
//  Hold ififo_full_i=1 for 10 cycles from IDLE -> stb stays 0, no write; resumes 1 cycle after full drops.
//  Redirect to 0x2002 while REQ pending 3 cycles -> flush pulse, DRAIN, stale data not written;
//   next adr=0x2000, first write has skip=1.
//  Redirect in same cycle as ack -> no write that cycle; next adr=target&~3.
//  fetch_pc_o=0xFFFFFFFC -> next adr wraps to 0x00000000.
//  SKID_EN: 0-wait memory, full asserted after one write -> second word held in skid,
//   written first when full drops; no word lost or duplicated.

Source files
------------

// File: rtl/cpu_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_fetch : fetch PC owner, word reads from imem, pushes into cpu_ififo   |
// | Option macro CPU_FETCH_SKID_EN : back-to-back fetch with one-word skid    |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cpu_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_stb_o,
   output logic [31:0] imem_adr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_dat_i,
   input  logic        ififo_full_i,
   output logic        ififo_write_en_o,
   output logic [31:0] ififo_data_o,
   output logic        ififo_flush_o,
   output logic        ififo_skip_o,
   output logic [31:0] fetch_pc_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;
   logic        stb;
   logic [31:0] adr;
   logic [31:0] pc;
   logic        flush;
   logic        skip_pend;
   logic        take;
   logic        direct_wr;
   logic        can_issue;
   logic        unused_tgt_lsb;

   // A response is usable only for a live request that is not being redirected away.
   assign take           = (state == REQ) && imem_ack_i && !branch_flag_i;
   assign unused_tgt_lsb = branch_target_i[0];

`ifdef CPU_FETCH_SKID_EN
   logic [31:0] skid_data;
   logic        skid_valid;
   logic        skid_skip;
   logic        skid_wr;

   assign direct_wr        = take && !ififo_full_i && !skid_valid && !rst_i;
   assign skid_wr          = skid_valid && !ififo_full_i && !branch_flag_i && !rst_i;
   assign can_issue        = !ififo_full_i && !skid_valid;
   assign ififo_write_en_o = direct_wr || skid_wr;
   assign ififo_data_o     = direct_wr ? imem_dat_i : (skid_wr ? skid_data : 32'h0);
   assign ififo_skip_o     = direct_wr ? skip_pend : (skid_wr && skid_skip);

   always_ff @(posedge clk_i) begin
      if (rst_i || branch_flag_i) begin
         skid_valid <= 1'b0;
         skid_data  <= 32'h0;
         skid_skip  <= 1'b0;
      end else if (skid_wr) begin
         skid_valid <= 1'b0;
      end else if (take && ififo_full_i) begin
         skid_valid <= 1'b1;
         skid_data  <= imem_dat_i;
         skid_skip  <= skip_pend;
      end
   end
`else
   assign direct_wr        = take && !ififo_full_i && !rst_i;
   assign can_issue        = !ififo_full_i;
   assign ififo_write_en_o = direct_wr;
   assign ififo_data_o     = direct_wr ? imem_dat_i : 32'h0;
   assign ififo_skip_o     = direct_wr && skip_pend;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         stb       <= 1'b0;
         adr       <= 32'h0;
         pc        <= RESET_VECTOR;
         flush     <= 1'b0;
         skip_pend <= 1'b0;
      end else begin
         flush <= branch_flag_i;
         if (branch_flag_i) begin
            pc        <= {branch_target_i[31:2], 2'b00};
            skip_pend <= branch_target_i[1];
            // An unanswered request must still be acked by memory before a new one may start.
            if (((state == REQ) || (state == DRAIN)) && !imem_ack_i) begin
               state <= DRAIN;
            end else begin
               state <= IDLE;
               stb   <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (can_issue) begin
                     stb   <= 1'b1;
                     adr   <= pc;
                     state <= REQ;
                  end
               end
               REQ: begin
                  if (imem_ack_i) begin
                     pc        <= pc + 32'd4;
                     skip_pend <= 1'b0;
`ifdef CPU_FETCH_SKID_EN
                     if (can_issue) begin
                        adr <= pc + 32'd4;
                     end else begin
                        stb   <= 1'b0;
                        state <= IDLE;
                     end
`else
                     stb   <= 1'b0;
                     state <= IDLE;
`endif
                  end
               end
               DRAIN: begin
                  if (imem_ack_i) begin
                     stb   <= 1'b0;
                     state <= IDLE;
                  end
               end
               default: begin
                  stb   <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign imem_stb_o    = stb;
   assign imem_adr_o    = adr;
   assign ififo_flush_o = flush;
   assign fetch_pc_o    = pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_fetch : self-checking bench for cpu_fetch with a latency memory    |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_cpu_fetch;

`ifdef CPU_FETCH_SKID_EN
   localparam int SPACING = 1;
`else
   localparam int SPACING = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_dat = 32'h0;
   logic        ififo_full = 1'b0;
   logic        imem_stb;
   logic [31:0] imem_adr;
   logic        ififo_write_en;
   logic [31:0] ififo_data;
   logic        ififo_flush;
   logic        ififo_skip;
   logic [31:0] fetch_pc;

   cpu_fetch #(.RESET_VECTOR(32'h0000_1000)) dut (
      .clk_i(clk), .rst_i(rst), .branch_flag_i(branch_flag), .branch_target_i(branch_target),
      .imem_stb_o(imem_stb), .imem_adr_o(imem_adr), .imem_ack_i(imem_ack), .imem_dat_i(imem_dat),
      .ififo_full_i(ififo_full), .ififo_write_en_o(ififo_write_en), .ififo_data_o(ififo_data),
      .ififo_flush_o(ififo_flush), .ififo_skip_o(ififo_skip), .fetch_pc_o(fetch_pc)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int lat_min = 0;
   int lat_max = 0;
   int lat_left = 0;
   bit req_active = 0;
   bit want_rst = 1;
   bit want_full = 0;
   bit rand_full = 0;

   logic        obs_stb, obs_we, obs_flush, obs_skip, obs_full, obs_ack;
   logic [31:0] obs_adr, obs_data, obs_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock: drive all inputs at the falling edge, sample outputs 1ns later.
   task automatic tick(input logic br, input logic [31:0] tgt);
      @(negedge clk);
      rst = want_rst;
      if (rand_full) begin
         if (!imem_stb) ififo_full = ($urandom_range(99, 0) < 30);
         else if ($urandom_range(1, 0) == 0) ififo_full = 1'b0;
      end else begin
         ififo_full = want_full;
      end
      imem_ack = 1'b0;
      imem_dat = $urandom();
      if (rst || !imem_stb) begin
         req_active = 0;
      end else begin
         if (!req_active) begin
            req_active = 1;
            lat_left   = $urandom_range(lat_max, lat_min);
         end
         if (lat_left == 0) begin
            imem_ack   = 1'b1;
            imem_dat   = mem_word(imem_adr);
            req_active = 0;
         end else begin
            lat_left--;
         end
      end
      branch_flag   = br;
      branch_target = tgt;
      #1;
      obs_stb = imem_stb;   obs_adr = imem_adr;     obs_we = ififo_write_en;
      obs_data = ififo_data; obs_flush = ififo_flush; obs_skip = ififo_skip;
      obs_pc = fetch_pc;    obs_full = ififo_full;  obs_ack = imem_ack;
   endtask

   task automatic do_reset();
      want_rst = 1;
      tick(1'b0, 32'h0);
      tick(1'b0, 32'h0);
      want_rst = 0;
   endtask

   task automatic test_reset();
      want_full = 0; lat_min = 0; lat_max = 0;
      want_rst = 1;
      tick(1'b0, 32'h0);
      tick(1'b0, 32'h0);
      checks++; if (obs_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%0h exp=0", obs_stb); end
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", obs_we); end
      checks++; if (obs_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0h exp=0", obs_flush); end
      checks++; if (obs_skip !== 1'b0) begin errors++; $display("FAIL reset_skip got=%0h exp=0", obs_skip); end
      checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%08h exp=0", obs_data); end
      checks++; if (obs_adr !== 32'h0) begin errors++; $display("FAIL reset_adr got=%08h exp=0", obs_adr); end
      checks++; if (obs_pc !== 32'h1000) begin errors++; $display("FAIL reset_pc got=%08h exp=00001000", obs_pc); end
   endtask

   task automatic test_sequential();
      int nw, last;
      bit seen;
      logic [31:0] exp;
      nw = 0; last = -1; seen = 0; exp = 32'h1000;
      lat_min = 0; lat_max = 0; want_full = 0;
      do_reset();
      for (int i = 0; i < 40 && nw < 5; i++) begin
         tick(1'b0, 32'h0);
         if (obs_stb && !seen) begin
            seen = 1;
            checks++; if (obs_adr !== 32'h1000) begin errors++; $display("FAIL seq_first_adr got=%08h exp=00001000", obs_adr); end
         end
         if (obs_we) begin
            checks++; if (obs_data !== mem_word(exp)) begin errors++; $display("FAIL seq_data addr=%08h got=%08h exp=%08h", exp, obs_data, mem_word(exp)); end
            checks++; if (obs_skip !== 1'b0) begin errors++; $display("FAIL seq_skip got=%0h exp=0", obs_skip); end
            if (last >= 0) begin
               checks++; if (i - last != SPACING) begin errors++; $display("FAIL seq_spacing got=%0d exp=%0d", i - last, SPACING); end
            end
            last = i; exp += 4; nw++;
         end
      end
      checks++; if (nw != 5) begin errors++; $display("FAIL seq_timeout writes=%0d exp=5", nw); end
   endtask

   task automatic test_full_hold();
      bit bad;
      lat_min = 0; lat_max = 0; want_full = 1;
      do_reset();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 32'h0);
         if (obs_stb !== 1'b0 || obs_we !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL full_hold_quiet got=activity exp=no stb/write"); end
      want_full = 0;
      tick(1'b0, 32'h0);
      checks++; if (obs_stb !== 1'b0) begin errors++; $display("FAIL full_drop_same_cycle stb got=%0h exp=0", obs_stb); end
      tick(1'b0, 32'h0);
      checks++; if (obs_stb !== 1'b1 || obs_adr !== 32'h1000) begin errors++; $display("FAIL full_resume stb=%0h adr=%08h exp stb=1 adr=00001000", obs_stb, obs_adr); end
      checks++; if (obs_we !== 1'b1 || obs_data !== mem_word(32'h1000)) begin errors++; $display("FAIL full_resume_write we=%0h data=%08h exp we=1 data=%08h", obs_we, obs_data, mem_word(32'h1000)); end
   endtask

   task automatic test_redirect_drain();
      bit got;
      lat_min = 3; lat_max = 3; want_full = 0;
      do_reset();
      tick(1'b0, 32'h0);
      tick(1'b0, 32'h0);
      tick(1'b0, 32'h0);
      tick(1'b1, 32'h0000_2002);
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL drain_redirect_we got=%0h exp=0", obs_we); end
      lat_min = 0; lat_max = 0;
      tick(1'b0, 32'h0);
      checks++; if (obs_flush !== 1'b1) begin errors++; $display("FAIL drain_flush got=%0h exp=1", obs_flush); end
      checks++; if (obs_stb !== 1'b1 || obs_adr !== 32'h1000) begin errors++; $display("FAIL drain_hold stb=%0h adr=%08h exp stb=1 adr=00001000", obs_stb, obs_adr); end
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL drain_stale_write got=%0h exp=0", obs_we); end
      checks++; if (obs_pc !== 32'h2000) begin errors++; $display("FAIL drain_pc got=%08h exp=00002000", obs_pc); end
      tick(1'b0, 32'h0);
      checks++; if (obs_flush !== 1'b0 || obs_we !== 1'b0) begin errors++; $display("FAIL drain_after flush=%0h we=%0h exp 0/0", obs_flush, obs_we); end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(1'b0, 32'h0);
         if (obs_we) begin
            got = 1;
            checks++; if (obs_adr !== 32'h2000) begin errors++; $display("FAIL drain_new_adr got=%08h exp=00002000", obs_adr); end
            checks++; if (obs_data !== mem_word(32'h2000) || obs_skip !== 1'b1) begin errors++; $display("FAIL drain_first_write data=%08h skip=%0h exp data=%08h skip=1", obs_data, obs_skip, mem_word(32'h2000)); end
         end
      end
      checks++; if (!got) begin errors++; $display("FAIL drain_timeout got=no write exp=write"); end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(1'b0, 32'h0);
         if (obs_we) begin
            got = 1;
            checks++; if (obs_data !== mem_word(32'h2004) || obs_skip !== 1'b0) begin errors++; $display("FAIL drain_second_write data=%08h skip=%0h exp data=%08h skip=0", obs_data, obs_skip, mem_word(32'h2004)); end
         end
      end
      checks++; if (!got) begin errors++; $display("FAIL drain_timeout2 got=no write exp=write"); end
   endtask

   task automatic test_redirect_ack();
      bit got;
      lat_min = 0; lat_max = 0; want_full = 0;
      do_reset();
      tick(1'b0, 32'h0);
      tick(1'b1, 32'h0000_3006);
      checks++; if (obs_ack !== 1'b1 || obs_we !== 1'b0) begin errors++; $display("FAIL ackredir_we ack=%0h we=%0h exp ack=1 we=0", obs_ack, obs_we); end
      tick(1'b0, 32'h0);
      checks++; if (obs_flush !== 1'b1 || obs_we !== 1'b0) begin errors++; $display("FAIL ackredir_flush flush=%0h we=%0h exp 1/0", obs_flush, obs_we); end
      checks++; if (obs_pc !== 32'h3004) begin errors++; $display("FAIL ackredir_pc got=%08h exp=00003004", obs_pc); end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(1'b0, 32'h0);
         if (obs_stb) begin
            got = 1;
            checks++; if (obs_adr !== 32'h3004) begin errors++; $display("FAIL ackredir_adr got=%08h exp=00003004", obs_adr); end
            checks++; if (obs_we !== 1'b1 || obs_skip !== 1'b1 || obs_data !== mem_word(32'h3004)) begin errors++; $display("FAIL ackredir_write we=%0h skip=%0h data=%08h exp 1/1/%08h", obs_we, obs_skip, obs_data, mem_word(32'h3004)); end
         end
      end
      checks++; if (!got) begin errors++; $display("FAIL ackredir_timeout got=no stb exp=stb"); end
   endtask

   task automatic test_wrap();
      bit got;
      lat_min = 0; lat_max = 0; want_full = 0;
      do_reset();
      tick(1'b1, 32'hFFFF_FFFC);
      tick(1'b0, 32'h0);
      checks++; if (obs_pc !== 32'hFFFF_FFFC || obs_flush !== 1'b1) begin errors++; $display("FAIL wrap_pc pc=%08h flush=%0h exp FFFFFFFC/1", obs_pc, obs_flush); end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(1'b0, 32'h0);
         if (obs_we) got = 1;
      end
      checks++; if (!got || obs_data !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_write got=%08h exp=%08h", obs_data, mem_word(32'hFFFF_FFFC)); end
      tick(1'b0, 32'h0);
      checks++; if (obs_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc_next got=%08h exp=00000000", obs_pc); end
      for (int i = 0; i < 5 && !obs_stb; i++) tick(1'b0, 32'h0);
      checks++; if (obs_stb !== 1'b1 || obs_adr !== 32'h0) begin errors++; $display("FAIL wrap_adr stb=%0h adr=%08h exp 1/00000000", obs_stb, obs_adr); end
   endtask

`ifdef CPU_FETCH_SKID_EN
   task automatic test_skid();
      int nw;
      logic [31:0] exp;
      lat_min = 0; lat_max = 0; want_full = 0;
      do_reset();
      tick(1'b0, 32'h0);
      tick(1'b0, 32'h0);
      checks++; if (obs_we !== 1'b1 || obs_data !== mem_word(32'h1000)) begin errors++; $display("FAIL skid_first we=%0h data=%08h exp 1/%08h", obs_we, obs_data, mem_word(32'h1000)); end
      want_full = 1;
      tick(1'b0, 32'h0);
      checks++; if (obs_ack !== 1'b1 || obs_we !== 1'b0) begin errors++; $display("FAIL skid_capture ack=%0h we=%0h exp 1/0", obs_ack, obs_we); end
      for (int i = 0; i < 5; i++) tick(1'b0, 32'h0);
      checks++; if (obs_we !== 1'b0 || obs_stb !== 1'b0) begin errors++; $display("FAIL skid_blocked we=%0h stb=%0h exp 0/0", obs_we, obs_stb); end
      want_full = 0;
      exp = 32'h1004; nw = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 32'h0);
         if (i == 0) begin
            checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL skid_drain_first got=%0h exp=1", obs_we); end
         end
         if (obs_we) begin
            checks++; if (obs_data !== mem_word(exp)) begin errors++; $display("FAIL skid_order addr=%08h got=%08h exp=%08h", exp, obs_data, mem_word(exp)); end
            exp += 4; nw++;
         end
      end
      checks++; if (nw < 3) begin errors++; $display("FAIL skid_count got=%0d exp>=3", nw); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] exp, tgt, prev_adr;
      bit exp_skip, br, prev_br, prev_stb, prev_ack;
      int nw;
      lat_min = 0; lat_max = 3; want_full = 0;
      do_reset();
      rand_full = 1;
      exp = 32'h1000; exp_skip = 0; nw = 0;
      prev_br = 0; prev_stb = 0; prev_ack = 0; prev_adr = 32'h0;
      for (int i = 0; i < 1500; i++) begin
         br  = ($urandom_range(99, 0) < 4);
         tgt = $urandom();
         tgt[0] = 1'b0;
         tick(br, tgt);
         if (obs_stb && prev_stb && !prev_ack) begin
            checks++; if (obs_adr !== prev_adr) begin errors++; $display("FAIL rnd_adr_stable cyc=%0d got=%08h exp=%08h", i, obs_adr, prev_adr); end
         end
         if (obs_stb) begin
            checks++; if (obs_adr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_adr_align cyc=%0d got=%08h", i, obs_adr); end
         end
         checks++; if (obs_flush !== prev_br) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%0h exp=%0h", i, obs_flush, prev_br); end
         if (br || obs_flush) begin
            checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL rnd_redirect_we cyc=%0d got=%0h exp=0", i, obs_we); end
         end
         if (br) begin
            exp = {tgt[31:2], 2'b00};
            exp_skip = tgt[1];
         end else if (obs_we) begin
            checks++; if (obs_full !== 1'b0) begin errors++; $display("FAIL rnd_we_full cyc=%0d full=%0h exp=0", i, obs_full); end
            checks++; if (obs_data !== mem_word(exp)) begin errors++; $display("FAIL rnd_data cyc=%0d addr=%08h got=%08h exp=%08h", i, exp, obs_data, mem_word(exp)); end
            checks++; if (obs_skip !== exp_skip) begin errors++; $display("FAIL rnd_skip cyc=%0d got=%0h exp=%0h", i, obs_skip, exp_skip); end
            exp += 4; exp_skip = 0; nw++;
         end
         prev_br = br; prev_stb = obs_stb; prev_ack = obs_ack; prev_adr = obs_adr;
      end
      rand_full = 0;
      checks++; if (nw < 100) begin errors++; $display("FAIL rnd_progress writes=%0d exp>=100", nw); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full_hold();
      test_redirect_drain();
      test_redirect_ack();
      test_wrap();
`ifdef CPU_FETCH_SKID_EN
      test_skid();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
